// File: rtl/veda_inst_mem_if.sv
`default_nettype none
// ============================================================================
// Module      : veda_inst_mem_if
// Description : Access bus for the VEDA instruction memory. It groups the
//               enable, mode, address and write data driven by a loader or
//               fetch stage with the registered read data that comes back.
// Ports       : w_en    - access enable (1 = perform the operation in mode)
//               mode    - 0 = write, 1 = read
//               address - word address
//               datain  - write data
//               dataout - registered read data
// Modports    : master - loader / fetch side (drives the request)
//               slave  - memory side (returns dataout)
// Revision    : 1.0 - initial release
// ============================================================================
interface veda_inst_mem_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 9
);

  logic              w_en;
  logic              mode;
  logic [ADDR_W-1:0] address;
  logic [DATA_W-1:0] datain;
  logic [DATA_W-1:0] dataout;

  modport master (
    output w_en,
    output mode,
    output address,
    output datain,
    input  dataout
  );

  modport slave (
    input  w_en,
    input  mode,
    input  address,
    input  datain,
    output dataout
  );

endinterface : veda_inst_mem_if
`default_nettype wire

// File: rtl/veda_inst_mem.sv
`default_nettype none
// ============================================================================
// Module      : veda_inst_mem
// Description : Single-port synchronous instruction memory, DEPTH x DATA_W.
//               One shared address bus; mode selects write or read and w_en
//               gates the whole access. Read data is registered, so it
//               appears one clock after the address is sampled. A
//               synchronous reset clears every word and the read register.
// Ports       : clk   - system clock, all state changes on the rising edge
//               rst_n - synchronous active-low reset (priority over access)
//               bus   - veda_inst_mem_if.slave (w_en, mode, address,
//                       datain, dataout)
// Revision    : 1.0 - initial release
// ============================================================================
module veda_inst_mem #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 9,
  parameter int DEPTH  = 512   // must equal 2**ADDR_W for a full decode
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  veda_inst_mem_if.slave   bus
);

  localparam logic C_MODE_WRITE = 1'b0;
  localparam logic C_MODE_READ  = 1'b1;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_dataout;

  logic w_wr;
  logic w_rd;

  assign w_wr = bus.w_en && (bus.mode == C_MODE_WRITE);
  assign w_rd = bus.w_en && (bus.mode == C_MODE_READ);

  // Storage array. Reset clears every word so a never-written location
  // reads back as zero and a reset in the middle of a load discards the
  // partial image.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_wr) begin
      r_mem[bus.address] <= bus.datain;
    end
  end

  // Read register: loads only on a read access and holds otherwise, so a
  // write or an idle cycle leaves the last fetched word on dataout.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_dataout <= '0;
    end else if (w_rd) begin
      r_dataout <= r_mem[bus.address];
    end
  end

  assign bus.dataout = r_dataout;

endmodule : veda_inst_mem
`default_nettype wire

// File: tb/tb_veda_inst_mem.sv
`default_nettype none
// ============================================================================
// Module      : tb_veda_inst_mem
// Description : Directed self-checking bench for veda_inst_mem. Each step
//               drives one request, lets one rising edge pass, then compares
//               dataout against a hand-computed value.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_veda_inst_mem;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 9;
  localparam int DEPTH  = 512;

  logic clk;
  logic rst_n;

  int n_checks;
  int n_fail;

  veda_inst_mem_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus_if ();

  veda_inst_mem #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [DATA_W-1:0] observed,
                          input logic [DATA_W-1:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_fail++;
      $display("FAIL %s: observed %08h expected %08h", tag, observed, expected);
    end
  endtask

  // Drive one request, pass one rising edge, settle 1 time unit after it.
  task automatic step(input logic en, input logic md,
                      input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] din);
    bus_if.w_en    = en;
    bus_if.mode    = md;
    bus_if.address = addr;
    bus_if.datain  = din;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;

    // Reset held for two edges while a write to 5 is requested.
    rst_n = 1'b0;
    step(1'b1, 1'b0, 9'd5, 32'hFFFF_FFFF);
    step(1'b1, 1'b0, 9'd5, 32'hFFFF_FFFF);
    check_eq("reset_dataout", bus_if.dataout, 32'h0);
    rst_n = 1'b1;
    step(1'b1, 1'b1, 9'd5, 32'h0);
    check_eq("reset_blocks_write", bus_if.dataout, 32'h0);

    // Write then read.
    step(1'b1, 1'b0, 9'd5, 32'd9);
    check_eq("no_write_through", bus_if.dataout, 32'h0);
    step(1'b1, 1'b1, 9'd5, 32'h0);
    check_eq("read_addr5", bus_if.dataout, 32'd9);

    // Unwritten word, then re-read.
    step(1'b1, 1'b1, 9'd1, 32'h0);
    check_eq("unwritten_addr1", bus_if.dataout, 32'h0);
    step(1'b1, 1'b1, 9'd5, 32'h0);
    check_eq("reread_addr5", bus_if.dataout, 32'd9);

    // Enable gating.
    step(1'b0, 1'b0, 9'd5, 32'hDEAD_BEEF);
    check_eq("idle_write_hold", bus_if.dataout, 32'd9);
    step(1'b0, 1'b1, 9'd1, 32'h0);
    check_eq("idle_read_hold", bus_if.dataout, 32'd9);
    step(1'b1, 1'b1, 9'd5, 32'h0);
    check_eq("idle_write_blocked", bus_if.dataout, 32'd9);
    step(1'b1, 1'b1, 9'd1, 32'h0);
    check_eq("read_addr1_again", bus_if.dataout, 32'h0);
    step(1'b0, 1'b1, 9'd5, 32'h0);
    check_eq("idle_read_no_load", bus_if.dataout, 32'h0);

    // Boundaries.
    step(1'b1, 1'b0, 9'd0,   32'hA5A5_A5A5);
    step(1'b1, 1'b0, 9'd511, 32'h5A5A_5A5A);
    check_eq("boundary_write_hold", bus_if.dataout, 32'h0);
    step(1'b1, 1'b1, 9'd0, 32'h0);
    check_eq("read_addr0", bus_if.dataout, 32'hA5A5_A5A5);
    step(1'b1, 1'b1, 9'd511, 32'h0);
    check_eq("read_addr511", bus_if.dataout, 32'h5A5A_5A5A);
    step(1'b1, 1'b1, 9'd256, 32'h0);
    check_eq("read_addr256", bus_if.dataout, 32'h0);
    step(1'b1, 1'b1, 9'd0, 32'h0);
    check_eq("reread_addr0", bus_if.dataout, 32'hA5A5_A5A5);

    // Write during held read data.
    step(1'b1, 1'b1, 9'd5, 32'h0);
    check_eq("read_before_write", bus_if.dataout, 32'd9);
    step(1'b1, 1'b0, 9'd7, 32'd3);
    check_eq("hold_through_write", bus_if.dataout, 32'd9);
    step(1'b1, 1'b1, 9'd7, 32'h0);
    check_eq("read_addr7", bus_if.dataout, 32'd3);

    // Reset in the middle of a load discards prior writes.
    step(1'b1, 1'b0, 9'd10, 32'h1234_5678);
    rst_n = 1'b0;
    step(1'b1, 1'b0, 9'd11, 32'h8765_4321);
    check_eq("midload_reset_dataout", bus_if.dataout, 32'h0);
    rst_n = 1'b1;
    step(1'b1, 1'b1, 9'd10, 32'h0);
    check_eq("midload_addr10_cleared", bus_if.dataout, 32'h0);
    step(1'b1, 1'b1, 9'd511, 32'h0);
    check_eq("midload_addr511_cleared", bus_if.dataout, 32'h0);
    step(1'b1, 1'b1, 9'd5, 32'h0);
    check_eq("midload_addr5_cleared", bus_if.dataout, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_veda_inst_mem
`default_nettype wire
